// File: rtl/bht_update_buffer.sv
// ---------------------------------------------------------------------------
// bht_update_buffer
//   Decouples resolved conditional-branch outcomes from the branch unit and
//   replays them to the BHT update port, at most one update per cycle.
//   Outcomes are queued in a circular FIFO. Pending work is discarded on
//   flush, and new outcomes are ignored while the core is in debug mode.
//
// Optional feature (compile-time macro BHT_UPD_COALESCE_EN):
//   When defined, a push whose PC equals the PC of the newest queued entry
//   overwrites that entry's outcome instead of allocating a new entry.
//   When undefined, every qualifying push allocates and no PC compare exists.
//
// Ports
//   clk_i            clock
//   rst_ni           asynchronous active-low reset
//   flush_i          drop every pending entry
//   debug_mode_i     core in debug mode: pushes suppressed, draining continues
//   resolve_valid_i  conditional branch resolved this cycle
//   resolve_pc_i     PC of the resolved branch
//   resolve_taken_i  branch outcome
//   upd_valid_o      head entry available
//   upd_pc_o         head entry PC (held while upd_valid_o=0)
//   upd_taken_o      head entry outcome (held while upd_valid_o=0)
//   upd_ready_i      BHT accepts the update this cycle
//   level_o          number of pending entries
//   overflow_cnt_o   saturating count of outcomes dropped because full
// ---------------------------------------------------------------------------
module bht_update_buffer #(
  parameter int VLEN  = 64,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       debug_mode_i,
  input  logic                       resolve_valid_i,
  input  logic [VLEN-1:0]            resolve_pc_i,
  input  logic                       resolve_taken_i,
  output logic                       upd_valid_o,
  output logic [VLEN-1:0]            upd_pc_o,
  output logic                       upd_taken_o,
  input  logic                       upd_ready_i,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic [CNT_W-1:0]           overflow_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic [PW-1:0]    PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Storage and pointers; pointers carry one extra wrap bit.
  logic [VLEN-1:0]  mem_pc_r    [DEPTH];
  logic             mem_taken_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;

  // Registered outputs.
  logic             upd_valid_r;
  logic [VLEN-1:0]  upd_pc_r;
  logic             upd_taken_r;
  logic [PW-1:0]    level_r;
  logic [CNT_W-1:0] ovf_cnt_r;

  // Next-state values.
  logic [PW-1:0]    wr_ptr_n_s;
  logic [PW-1:0]    rd_ptr_n_s;
  logic             upd_valid_n_s;
  logic [VLEN-1:0]  upd_pc_n_s;
  logic             upd_taken_n_s;
  logic [CNT_W-1:0] ovf_cnt_n_s;

  logic             empty_s;
  logic             full_s;
  logic             push_req_s;
  logic             pop_s;
  logic             coalesce_s;
  logic             alloc_s;
  logic             drop_s;
  logic [AW-1:0]    wr_idx_s;
  logic [AW-1:0]    rd_idx_n_s;

  assign wr_idx_s   = wr_ptr_r[AW-1:0];
  assign rd_idx_n_s = rd_ptr_n_s[AW-1:0];
  assign empty_s    = (wr_ptr_r == rd_ptr_r);
  assign full_s     = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                      (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);

  // Flush wins over both push and pop in the same cycle.
  assign push_req_s = resolve_valid_i && !debug_mode_i && !flush_i;
  assign pop_s      = upd_valid_r && upd_ready_i && !flush_i;

`ifdef BHT_UPD_COALESCE_EN
  logic [AW-1:0] newest_idx_s;
  logic [PW-1:0] newest_ptr_s;

  assign newest_ptr_s = wr_ptr_r - PTR_ONE;
  assign newest_idx_s = newest_ptr_s[AW-1:0];
  // A single entry that is leaving this cycle cannot absorb the new outcome.
  assign coalesce_s   = push_req_s && !empty_s &&
                        (resolve_pc_i == mem_pc_r[newest_idx_s]) &&
                        !(pop_s && (level_r == PTR_ONE));
`else
  assign coalesce_s   = 1'b0;
`endif

  // A full FIFO still accepts when the head leaves in the same cycle.
  assign alloc_s = push_req_s && !coalesce_s && (!full_s || pop_s);
  assign drop_s  = push_req_s && !coalesce_s && full_s && !pop_s;

  // Next-state computation for pointers, counter and head registers.
  always_comb begin
    wr_ptr_n_s    = wr_ptr_r;
    rd_ptr_n_s    = rd_ptr_r;
    upd_valid_n_s = upd_valid_r;
    upd_pc_n_s    = upd_pc_r;
    upd_taken_n_s = upd_taken_r;
    ovf_cnt_n_s   = ovf_cnt_r;

    if (flush_i) begin
      rd_ptr_n_s = wr_ptr_r;
      wr_ptr_n_s = wr_ptr_r;
    end else begin
      if (pop_s) begin
        rd_ptr_n_s = rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_n_s = rd_ptr_r;
      end
      if (alloc_s) begin
        wr_ptr_n_s = wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_n_s = wr_ptr_r;
      end
    end

    if (drop_s && (ovf_cnt_r != CNT_MAX)) begin
      ovf_cnt_n_s = ovf_cnt_r + CNT_ONE;
    end else begin
      ovf_cnt_n_s = ovf_cnt_r;
    end

    // Head registers follow the next head slot, including data written
    // into that slot this cycle; they hold their value when empty.
    if (wr_ptr_n_s == rd_ptr_n_s) begin
      upd_valid_n_s = 1'b0;
    end else begin
      upd_valid_n_s = 1'b1;
      if (alloc_s && (wr_idx_s == rd_idx_n_s)) begin
        upd_pc_n_s    = resolve_pc_i;
        upd_taken_n_s = resolve_taken_i;
`ifdef BHT_UPD_COALESCE_EN
      end else if (coalesce_s && (newest_idx_s == rd_idx_n_s)) begin
        upd_pc_n_s    = mem_pc_r[rd_idx_n_s];
        upd_taken_n_s = resolve_taken_i;
`endif
      end else begin
        upd_pc_n_s    = mem_pc_r[rd_idx_n_s];
        upd_taken_n_s = mem_taken_r[rd_idx_n_s];
      end
    end
  end

  // FIFO entry storage: allocate at the write slot or update the newest outcome.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc_r[i]    <= {VLEN{1'b0}};
        mem_taken_r[i] <= 1'b0;
      end
    end else if (alloc_s) begin
      mem_pc_r[wr_idx_s]    <= resolve_pc_i;
      mem_taken_r[wr_idx_s] <= resolve_taken_i;
`ifdef BHT_UPD_COALESCE_EN
    end else if (coalesce_s) begin
      mem_taken_r[newest_idx_s] <= resolve_taken_i;
`endif
    end
  end

  // Pointer, level, counter and head-output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_r    <= {PW{1'b0}};
      rd_ptr_r    <= {PW{1'b0}};
      level_r     <= {PW{1'b0}};
      ovf_cnt_r   <= {CNT_W{1'b0}};
      upd_valid_r <= 1'b0;
      upd_pc_r    <= {VLEN{1'b0}};
      upd_taken_r <= 1'b0;
    end else begin
      wr_ptr_r    <= wr_ptr_n_s;
      rd_ptr_r    <= rd_ptr_n_s;
      level_r     <= wr_ptr_n_s - rd_ptr_n_s;
      ovf_cnt_r   <= ovf_cnt_n_s;
      upd_valid_r <= upd_valid_n_s;
      upd_pc_r    <= upd_pc_n_s;
      upd_taken_r <= upd_taken_n_s;
    end
  end

  assign upd_valid_o    = upd_valid_r;
  assign upd_pc_o       = upd_pc_r;
  assign upd_taken_o    = upd_taken_r;
  assign level_o        = level_r;
  assign overflow_cnt_o = ovf_cnt_r;

endmodule

// File: tb/tb_bht_update_buffer.sv
// ---------------------------------------------------------------------------
// tb_bht_update_buffer
//   Self-checking bench for bht_update_buffer (VLEN=64, DEPTH=4, CNT_W=8).
//   A table of per-cycle stimulus records carries the expected level and
//   overflow count after each cycle; a queue model holds the entries the
//   DUT must emit, in order, and is compared against upd_* every cycle.
// ---------------------------------------------------------------------------
module tb_bht_update_buffer;

  localparam int VLEN  = 64;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef BHT_UPD_COALESCE_EN
  localparam int COAL  = 1;
`else
  localparam int COAL  = 0;
`endif

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             flush_i;
  logic             debug_mode_i;
  logic             resolve_valid_i;
  logic [VLEN-1:0]  resolve_pc_i;
  logic             resolve_taken_i;
  logic             upd_valid_o;
  logic [VLEN-1:0]  upd_pc_o;
  logic             upd_taken_o;
  logic             upd_ready_i;
  logic [LW-1:0]    level_o;
  logic [CNT_W-1:0] overflow_cnt_o;

  always #5 clk_i = ~clk_i;

  bht_update_buffer #(.VLEN(VLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .flush_i         (flush_i),
    .debug_mode_i    (debug_mode_i),
    .resolve_valid_i (resolve_valid_i),
    .resolve_pc_i    (resolve_pc_i),
    .resolve_taken_i (resolve_taken_i),
    .upd_valid_o     (upd_valid_o),
    .upd_pc_o        (upd_pc_o),
    .upd_taken_o     (upd_taken_o),
    .upd_ready_i     (upd_ready_i),
    .level_o         (level_o),
    .overflow_cnt_o  (overflow_cnt_o)
  );

  typedef struct {
    logic            v;
    logic [VLEN-1:0] pc;
    logic            t;
    logic            rdy;
    logic            fl;
    logic            dbg;
    int              lvl;
    int              ovf;
  } vec_t;

  typedef struct {
    logic [VLEN-1:0] pc;
    logic            t;
  } ent_t;

  localparam int NVEC = 24;
  vec_t vecs [NVEC];

  ent_t            sb_q[$];
  int              m_ovf;
  logic [VLEN-1:0] m_pc;
  logic            m_t;
  int              checks;
  int              errors;

  task automatic check(input string name, input logic [VLEN-1:0] act,
                       input logic [VLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    check("upd_valid", VLEN'(upd_valid_o), VLEN'(sb_q.size() != 0));
    check("level", VLEN'(level_o), VLEN'(sb_q.size()));
    check("overflow_cnt", VLEN'(overflow_cnt_o), VLEN'(m_ovf));
    check("upd_pc", upd_pc_o, m_pc);
    check("upd_taken", VLEN'(upd_taken_o), VLEN'(m_t));
  endtask

  // Called at posedge+1: compare current outputs, advance the model, clock.
  task automatic step(input logic v, input logic [VLEN-1:0] pc, input logic t,
                      input logic rdy, input logic fl, input logic dbg);
    int sz;
    bit pop;
    bit push;
    bit coal;
    resolve_valid_i = v;
    resolve_pc_i    = pc;
    resolve_taken_i = t;
    upd_ready_i     = rdy;
    flush_i         = fl;
    debug_mode_i    = dbg;
    compare_outputs();
    sz   = sb_q.size();
    pop  = (sz != 0) && rdy && !fl;
    push = v && !dbg && !fl;
    coal = 1'b0;
    if (COAL != 0 && push && sz != 0 && sb_q[sz-1].pc == pc && !(pop && sz == 1))
      coal = 1'b1;
    if (fl) begin
      sb_q.delete();
    end else begin
      if (coal) sb_q[sz-1].t = t;
      if (pop) void'(sb_q.pop_front());
      if (push && !coal) begin
        if (sz < DEPTH || pop) sb_q.push_back('{pc, t});
        else if (m_ovf < CMAX) m_ovf++;
      end
    end
    if (sb_q.size() != 0) begin
      m_pc = sb_q[0].pc;
      m_t  = sb_q[0].t;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, {VLEN{1'b0}}, 1'b0, rdy, 1'b0, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_ovf  = 0;
    m_pc   = {VLEN{1'b0}};
    m_t    = 1'b0;
    rst_ni          = 1'b0;
    flush_i         = 1'b0;
    debug_mode_i    = 1'b0;
    resolve_valid_i = 1'b0;
    resolve_pc_i    = {VLEN{1'b0}};
    resolve_taken_i = 1'b0;
    upd_ready_i     = 1'b0;

    //          v     pc                    t     rdy   fl    dbg   lvl  ovf
    vecs[0]  = '{1'b1, 64'h0000_0000_8000_0010, 1'b1, 1'b1, 1'b0, 1'b0, 1, 0};
    vecs[1]  = '{1'b0, 64'h0,   1'b0, 1'b1, 1'b0, 1'b0, 0, 0};
    vecs[2]  = '{1'b1, 64'h100, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0};
    vecs[3]  = '{1'b1, 64'h104, 1'b0, 1'b0, 1'b0, 1'b0, 2, 0};
    vecs[4]  = '{1'b1, 64'h108, 1'b1, 1'b0, 1'b0, 1'b0, 3, 0};
    vecs[5]  = '{1'b1, 64'h10C, 1'b0, 1'b0, 1'b0, 1'b0, 4, 0};
    vecs[6]  = '{1'b1, 64'h110, 1'b1, 1'b0, 1'b0, 1'b0, 4, 1};
    vecs[7]  = '{1'b1, 64'h200, 1'b1, 1'b1, 1'b0, 1'b0, 4, 1};
    vecs[8]  = '{1'b0, 64'h0,   1'b0, 1'b1, 1'b0, 1'b0, 3, 1};
    vecs[9]  = '{1'b0, 64'h0,   1'b0, 1'b1, 1'b0, 1'b0, 2, 1};
    vecs[10] = '{1'b0, 64'h0,   1'b0, 1'b1, 1'b0, 1'b0, 1, 1};
    vecs[11] = '{1'b0, 64'h0,   1'b0, 1'b1, 1'b0, 1'b0, 0, 1};
    vecs[12] = '{1'b1, 64'h0A0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1};
    vecs[13] = '{1'b1, 64'h0A4, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1};
    vecs[14] = '{1'b1, 64'h0A8, 1'b1, 1'b0, 1'b0, 1'b0, 3, 1};
    vecs[15] = '{1'b1, 64'h300, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1};
    vecs[16] = '{1'b0, 64'h0,   1'b0, 1'b1, 1'b0, 1'b0, 0, 1};
    vecs[17] = '{1'b1, 64'h0B0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1};
    vecs[18] = '{1'b1, 64'h400, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1};
    vecs[19] = '{1'b0, 64'h0,   1'b0, 1'b1, 1'b0, 1'b1, 0, 1};
    vecs[20] = '{1'b1, 64'h500, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1};
    vecs[21] = '{1'b1, 64'h500, 1'b0, 1'b0, 1'b0, 1'b0, 2 - COAL, 1};
    vecs[22] = '{1'b0, 64'h0,   1'b0, 1'b1, 1'b0, 1'b0, 1 - COAL, 1};
    vecs[23] = '{1'b0, 64'h0,   1'b0, 1'b1, 1'b0, 1'b0, 0, 1};

    repeat (2) @(posedge clk_i);
    #1;
    compare_outputs();
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Table-driven cycles with hand-derived level and overflow expectations.
    for (int i = 0; i < NVEC; i++) begin
      step(vecs[i].v, vecs[i].pc, vecs[i].t, vecs[i].rdy, vecs[i].fl, vecs[i].dbg);
      check($sformatf("vec%0d_level", i), VLEN'(level_o), VLEN'(vecs[i].lvl));
      check($sformatf("vec%0d_ovf", i), VLEN'(overflow_cnt_o), VLEN'(vecs[i].ovf));
    end

    // Overflow counter saturation: fill, then keep pushing while stalled.
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, VLEN'(64'h600 + 4 * i), i[0], 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++)
      step(1'b1, VLEN'(64'h700 + 4 * i), 1'b1, 1'b0, 1'b0, 1'b0);
    check("ovf_saturated", VLEN'(overflow_cnt_o), VLEN'(CMAX));
    for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);
    check("drained_after_sat", VLEN'(level_o), VLEN'(0));

    // Head must stay stable while stalled with random ready bursts.
    for (int i = 0; i < 40; i++)
      step(1'($urandom_range(0, 1)), VLEN'(64'h800 + 4 * $urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);

    // Asynchronous reset in the middle of a cycle with entries pending.
    step(1'b1, 64'h900, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'h904, 1'b1, 1'b0, 1'b0, 1'b0);
    upd_ready_i = 1'b1;
    #2;
    rst_ni = 1'b0;
    #1;
    check("arst_valid", VLEN'(upd_valid_o), VLEN'(0));
    check("arst_level", VLEN'(level_o), VLEN'(0));
    check("arst_ovf", VLEN'(overflow_cnt_o), VLEN'(0));
    check("arst_pc", upd_pc_o, VLEN'(0));
    check("arst_taken", VLEN'(upd_taken_o), VLEN'(0));
    sb_q.delete();
    m_ovf = 0;
    m_pc  = {VLEN{1'b0}};
    m_t   = 1'b0;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    idle(1'b1);
    step(1'b1, 64'hA00, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
